mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
// Shares the single-ported CPU memory between the instruction-fetch unit (IF, read-only)
// and the load/store unit (LS, read/write).
// - Arbitrates one access per cycle and drives the memory address and write controls.
// - Registers the combinational read data into per-requester response slots.
// - LS normally has priority; a starvation counter guarantees IF forward progress.
// - if_flush discards a stale fetch response on a branch redirect.
// PARAMETERS
// ADDR_WIDTH    32  byte-address width
// DATA_WIDTH    32  word width; multiple of 8; NB = DATA_WIDTH/8 bytes per word
// BW            $clog2(DATA_WIDTH/8)+1  width of byte-count fields (0..NB)
// STARVE_LIMIT  4   consecutive lost IF arbitrations before IF is forced to win (>=1)
// PORTS
// clk            in   1           clock
// rst            in   1           synchronous active-high reset
// if_req_valid   in   1           IF read request
// if_req_ready   out  1           IF request accepted this cycle
// if_req_addr    in   ADDR_WIDTH  IF byte address
// if_flush       in   1           drop IF response slot; block IF grant this cycle
// if_rsp_valid   out  1           IF response slot full
// if_rsp_ready   in   1           IF consumes response
// if_rsp_data    out  DATA_WIDTH  fetched word
// ls_req_valid   in   1           LS request
// ls_req_ready   out  1           LS request accepted this cycle
// ls_req_addr    in   ADDR_WIDTH  LS byte address
// ls_req_write   in   1           1 = write, 0 = read
// ls_req_bytes   in   BW          bytes to write (writes only); values >NB clamp to NB
// ls_req_wdata   in   DATA_WIDTH  write data, byte i = bits [8i+:8]
// ls_rsp_valid   out  1           LS response slot full (read data or write ack)
// ls_rsp_ready   in   1           LS consumes response
// ls_rsp_data    out  DATA_WIDTH  read word; 0 for write acks
// mem_addr       out  ADDR_WIDTH  memory address (read and write)
// mem_write_bytes out BW          byte-write count to memory; 0 = no write
// mem_write_data out  DATA_WIDTH  memory write data
// mem_read_data  in   DATA_WIDTH  combinational memory read of mem_addr
// BEHAVIOUR
// - Reset: if/ls_rsp_valid=0, if/ls_rsp_data=0, starve_cnt=0.
//   While rst is high: req_ready=0, mem_write_bytes=0, mem_addr=0.
// - Each response slot has two states, EMPTY and FULL.
//   - EMPTY->FULL on a grant to that requester.
//   - FULL->EMPTY on rsp_valid&&rsp_ready with no new grant.
//   - FULL->FULL when the response drains and a new grant occurs in the same cycle.
//   - A FULL slot holds rsp_data stable until it is consumed.
// - Eligibility (combinational):
//   - X_elig = X_req_valid && (slot EMPTY || X_rsp_ready).
//   - IF additionally requires !if_flush.
// - Arbitration:
//   - Only IF eligible -> IF wins. Only LS eligible -> LS wins.
//   - Both eligible -> LS wins unless starve_cnt==STARVE_LIMIT, in which case IF wins.
//   - The winner's req_ready is 1; the loser's req_ready is 0. A grant is req_valid&&req_ready.
// - starve_cnt:
//   - +1 (saturating at STARVE_LIMIT) when IF is eligible and LS wins.
//   - Cleared to 0 on an IF grant. Otherwise held.
// - Memory drive in the grant cycle:
//   - mem_addr = winner address.
//   - mem_write_bytes = min(ls_req_bytes,NB) for an LS write, else 0.
//   - mem_write_data = ls_req_wdata.
//   - No grant: mem_addr=0, mem_write_bytes=0.
// - Latency: a grant at edge N is followed by rsp_valid=1 after edge N+1.
//   - Reads capture mem_read_data at edge N+1. Write acks carry data 0.
// - Throughput: one access per cycle total.
//   - A requester with a FULL slot and rsp_ready=0 is not granted.
// - Ordering: an LS write granted in cycle N is visible to any read granted in cycle N+1 or later.
// - if_flush:
//   - Forces if_rsp_valid=0 after the edge, even if if_rsp_ready=0.
//   - Blocks any IF grant that cycle.
//   - Does not alter starve_cnt.
// - ls_req_bytes=0 on a write: no bytes are written; the ack is still returned.
// - Addresses pass through unchanged; alignment is not checked.
// TESTING
// 1. IF-only: if_req addr 0x10 -> if_req_ready=1 same cycle; next cycle if_rsp_valid=1 with word@0x10.
// 2. LS write addr 0x20, bytes=4, data 0xDEADBEEF, then IF read 0x20 -> if_rsp_data=0xDEADBEEF.
// 3. Both requesting every cycle, rsp_ready=1: grant pattern LS,LS,LS,LS,IF repeating.
// 4. ls_rsp_ready=0 after 1st LS read: LS blocked, IF granted every cycle; ls_rsp_data stable.
// 5. if_flush while if_rsp_valid=1, if_rsp_ready=0 -> if_rsp_valid=0 next cycle, no IF grant.
// 6. rst asserted mid-stream with both slots FULL -> all rsp_valid=0, starve_cnt=0, mem_write_bytes=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between the instruction-fetch (read-only)
// and load/store units, with registered per-requester response slots and IF anti-starvation.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BW           = $clog2(DATA_WIDTH/8)+1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_if_req_valid,
  output logic                  o_if_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_if_req_addr,
  input  logic                  i_if_flush,
  output logic                  o_if_rsp_valid,
  input  logic                  i_if_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_if_rsp_data,
  input  logic                  i_ls_req_valid,
  output logic                  o_ls_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_ls_req_addr,
  input  logic                  i_ls_req_write,
  input  logic [BW-1:0]         i_ls_req_bytes,
  input  logic [DATA_WIDTH-1:0] i_ls_req_wdata,
  output logic                  o_ls_rsp_valid,
  input  logic                  i_ls_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_ls_rsp_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [BW-1:0]         o_mem_write_bytes,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data
);

  localparam int NB = DATA_WIDTH/8;
  localparam int CW = $clog2(STARVE_LIMIT+1);

  typedef enum logic {EMPTY, FULL} slot_t;

  slot_t                 r_ifSlot, r_lsSlot;
  slot_t                 w_ifSlotNext, w_lsSlotNext;
  logic [CW-1:0]         r_starveCnt;
  logic [DATA_WIDTH-1:0] r_ifData, r_lsData;
  logic                  w_ifElig, w_lsElig, w_ifWin, w_lsWin, w_starved;
  logic [BW-1:0]         w_wrBytes;

  // A requester may take a new access only if its slot is free or drains this same cycle.
  assign w_ifElig  = i_if_req_valid && (r_ifSlot == EMPTY || i_if_rsp_ready) && !i_if_flush;
  assign w_lsElig  = i_ls_req_valid && (r_lsSlot == EMPTY || i_ls_rsp_ready);
  assign w_starved = (r_starveCnt == CW'(STARVE_LIMIT));
  assign w_ifWin   = !rst && w_ifElig && (!w_lsElig || w_starved);
  assign w_lsWin   = !rst && w_lsElig && !w_ifWin;
  assign w_wrBytes = (i_ls_req_bytes > BW'(NB)) ? BW'(NB) : i_ls_req_bytes;

  assign o_if_req_ready    = w_ifWin;
  assign o_ls_req_ready    = w_lsWin;
  assign o_mem_addr        = w_ifWin ? i_if_req_addr : (w_lsWin ? i_ls_req_addr : '0);
  assign o_mem_write_bytes = (w_lsWin && i_ls_req_write) ? w_wrBytes : '0;
  assign o_mem_write_data  = i_ls_req_wdata;

  assign o_if_rsp_valid = (r_ifSlot == FULL);
  assign o_ls_rsp_valid = (r_lsSlot == FULL);
  assign o_if_rsp_data  = r_ifData;
  assign o_ls_rsp_data  = r_lsData;

  // Flush wins over everything for the IF slot; a grant refills a draining slot.
  always_comb begin
    w_ifSlotNext = r_ifSlot;
    w_lsSlotNext = r_lsSlot;
    if (i_if_flush)
      w_ifSlotNext = EMPTY;
    else if (w_ifWin)
      w_ifSlotNext = FULL;
    else if (r_ifSlot == FULL && i_if_rsp_ready)
      w_ifSlotNext = EMPTY;
    if (w_lsWin)
      w_lsSlotNext = FULL;
    else if (r_lsSlot == FULL && i_ls_rsp_ready)
      w_lsSlotNext = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifSlot    <= EMPTY;
      r_lsSlot    <= EMPTY;
      r_ifData    <= '0;
      r_lsData    <= '0;
      r_starveCnt <= '0;
    end else begin
      r_ifSlot <= w_ifSlotNext;
      r_lsSlot <= w_lsSlotNext;
      if (w_ifWin)
        r_ifData <= i_mem_read_data;
      if (w_lsWin)
        r_lsData <= i_ls_req_write ? '0 : i_mem_read_data;
      // Count only arbitrations IF actually lost to LS.
      if (w_ifWin)
        r_starveCnt <= '0;
      else if (w_ifElig && w_lsWin && !w_starved)
        r_starveCnt <= r_starveCnt + CW'(1);
    end
  end

endmodule
